// File: rtl/bsmvm_pkg.sv
// Shared constants and types for the bit-serial MVM sequencer.
// Imported by the interface, the plane generator and the top.
package bsmvm_pkg;
   localparam int N_ELEM  = 32;
   localparam int ABITS   = 4;
   localparam int WBITS   = 4;
   localparam int OUT_W   = 13;
   localparam int N_COL   = 4;
   localparam int TIMEOUT = 64;
   localparam int PV_W    = N_ELEM * WBITS;
   localparam int WROW_W  = N_COL * WBITS;
   localparam int RES_W   = N_COL * OUT_W;
   localparam int P_W     = $clog2(ABITS);
   localparam int CNT_W   = $clog2(TIMEOUT);
   localparam int IDX_W   = $clog2(N_ELEM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef logic [PV_W-1:0]   plane_t;
   typedef logic [WROW_W-1:0] wrow_t;
endpackage

// File: rtl/bitserial_mvm_ctrl_if.sv
// Row, datapath and result handshakes of the MVM sequencer.
// master = controller side, slave = environment side.
interface bitserial_mvm_ctrl_if;
   import bsmvm_pkg::*;

   logic                 act_valid;
   logic                 act_ready;
   plane_t               act_data;
   logic                 dp_in_valid;
   plane_t               dp_in_data1;
   plane_t               dp_in_data2;
   plane_t               dp_in_data3;
   plane_t               dp_in_data4;
   logic                 dp_out_valid;
   logic [OUT_W-1:0]     dp_O1;
   logic [OUT_W-1:0]     dp_O2;
   logic [OUT_W-1:0]     dp_O3;
   logic [OUT_W-1:0]     dp_O4;
   logic                 res_valid;
   logic                 res_ready;
   logic [RES_W-1:0]     res_data;
   logic [1:0]           res_tag;

   modport master (
      input  act_valid, act_data, dp_out_valid,
      input  dp_O1, dp_O2, dp_O3, dp_O4, res_ready,
      output act_ready, dp_in_valid,
      output dp_in_data1, dp_in_data2, dp_in_data3, dp_in_data4,
      output res_valid, res_data, res_tag
   );

   modport slave (
      output act_valid, act_data, dp_out_valid,
      output dp_O1, dp_O2, dp_O3, dp_O4, res_ready,
      input  act_ready, dp_in_valid,
      input  dp_in_data1, dp_in_data2, dp_in_data3, dp_in_data4,
      input  res_valid, res_data, res_tag
   );
endinterface

// File: rtl/bsmvm_plane_gen.sv
// Builds one bit-plane per column: activation bit p of each
// element gates that element's weight nibble for the column.
module bsmvm_plane_gen
   import bsmvm_pkg::*;
(
   input  plane_t                        act,
   input  logic [N_ELEM-1:0][WROW_W-1:0] w,
   input  logic [P_W-1:0]                p,
   output logic [N_COL-1:0][PV_W-1:0]    plane
);

   // AND-mask every weight nibble with the selected activation bit
   always_comb begin
      plane = '0;
      for (int k = 0; k < N_ELEM; k++) begin
         for (int c = 0; c < N_COL; c++) begin
            plane[c][k*WBITS +: WBITS] =
               {WBITS{act[k*ABITS + int'(p)]}} & w[k][c*WBITS +: WBITS];
         end
      end
   end

endmodule

// File: rtl/bitserial_mvm_ctrl.sv
// Bit-serial MVM sequencer: weight regfile, row accept,
// MSB-first plane issue, result capture with timeout.
module bitserial_mvm_ctrl
   import bsmvm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_we,
   input  logic [IDX_W-1:0]      w_idx,
   input  logic [WROW_W-1:0]     w_data,
   bitserial_mvm_ctrl_if.master  bus,
   output logic                  err
);

   state_t                        state;
   state_t                        nxt;
   logic [N_ELEM-1:0][WROW_W-1:0] wreg;
   plane_t                        act_q;
   logic [P_W-1:0]                p_q;
   logic [CNT_W-1:0]              wcnt;
   logic [RES_W-1:0]              res_q;
   logic [1:0]                    tag;
   logic [N_COL-1:0][PV_W-1:0]    plane;
   logic                          issue;
   logic                          accept;
   logic                          tmo;

   assign issue  = (state == S_ISSUE);
   assign accept = (state == S_IDLE) && bus.act_valid;
   assign tmo    = (state == S_WAIT) && !bus.dp_out_valid
                   && (wcnt == CNT_W'(TIMEOUT-1));

   bsmvm_plane_gen u_gen (
      .act   (act_q),
      .w     (wreg),
      .p     (p_q),
      .plane (plane)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   // next-state logic
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (bus.act_valid) nxt = S_ISSUE;
         S_ISSUE: if (p_q == '0) nxt = S_WAIT;
         S_WAIT: begin
            if (bus.dp_out_valid) nxt = S_RESP;
            else if (tmo)         nxt = S_IDLE;
         end
         S_RESP:  if (bus.res_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // outputs decoded from state; planes forced to 0 when idle
   always_comb begin
      bus.act_ready   = rst_n && (state == S_IDLE);
      bus.dp_in_valid = issue;
      bus.dp_in_data1 = issue ? plane[0] : '0;
      bus.dp_in_data2 = issue ? plane[1] : '0;
      bus.dp_in_data3 = issue ? plane[2] : '0;
      bus.dp_in_data4 = issue ? plane[3] : '0;
      bus.res_valid   = (state == S_RESP);
      bus.res_data    = res_q;
      bus.res_tag     = tag;
   end

   // weight regfile, writable only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        wreg <= '0;
      else if (state == S_IDLE && w_we)  wreg[w_idx] <= w_data;
   end

   // row latch, plane index and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= '0;
         p_q   <= '0;
         wcnt  <= '0;
      end else begin
         if (accept) begin
            act_q <= bus.act_data;
            p_q   <= P_W'(ABITS-1);
         end else if (issue) begin
            p_q <= p_q - 1'b1;
         end
         if (state == S_WAIT) wcnt <= wcnt + 1'b1;
         else                 wcnt <= '0;
      end
   end

   // result capture, tag sequence and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         tag   <= '0;
         err   <= 1'b0;
      end else begin
         if (state == S_WAIT && bus.dp_out_valid)
            res_q <= {bus.dp_O4, bus.dp_O3, bus.dp_O2, bus.dp_O1};
         if (tmo || (state == S_RESP && bus.res_ready))
            tag <= tag + 1'b1;
         if (tmo || (state != S_WAIT && bus.dp_out_valid))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bitserial_mvm_ctrl.sv
// Self-checking bench for bitserial_mvm_ctrl with a
// bit-serial datapath model and an arithmetic golden model.
module tb_bitserial_mvm_ctrl;
   import bsmvm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        w_we = 1'b0;
   logic [4:0]  w_idx = '0;
   logic [15:0] w_data = '0;
   logic        err;

   bitserial_mvm_ctrl_if bus ();

   bitserial_mvm_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .w_we   (w_we),
      .w_idx  (w_idx),
      .w_data (w_data),
      .bus    (bus.master),
      .err    (err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int wref [N_ELEM][N_COL];
   int tag_m = 0;

   // datapath model: shift-accumulate column sums of each plane
   logic        dpv = 1'b0;
   logic        spur = 1'b0;
   logic        dp_mute = 1'b0;
   logic [12:0] o [4];
   int          acc [4];
   int          np = 0;
   int          tot_planes = 0;
   int          nz_cnt = 0;
   logic [3:0]  log1 [$];
   logic [3:0]  log4 [$];

   assign bus.dp_out_valid = dpv | spur;
   assign bus.dp_O1 = o[0];
   assign bus.dp_O2 = o[1];
   assign bus.dp_O3 = o[2];
   assign bus.dp_O4 = o[3];

   function automatic int colsum(logic [127:0] v);
      int s = 0;
      for (int k = 0; k < 32; k++) s += int'(v[k*4 +: 4]);
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dpv <= 1'b0;
         np = 0;
         for (int c = 0; c < 4; c++) begin
            acc[c] = 0;
            o[c] <= '0;
         end
      end else begin
         dpv <= 1'b0;
         if (bus.dp_in_valid) begin
            logic [127:0] m;
            int nx [4];
            nx[0] = acc[0] * 2 + colsum(bus.dp_in_data1);
            nx[1] = acc[1] * 2 + colsum(bus.dp_in_data2);
            nx[2] = acc[2] * 2 + colsum(bus.dp_in_data3);
            nx[3] = acc[3] * 2 + colsum(bus.dp_in_data4);
            log1.push_back(bus.dp_in_data1[3:0]);
            log4.push_back(bus.dp_in_data4[3:0]);
            m = bus.dp_in_data1 | bus.dp_in_data2
              | bus.dp_in_data3 | bus.dp_in_data4;
            if ((m & ~128'hF) != '0) nz_cnt++;
            tot_planes++;
            if (np == 3) begin
               np = 0;
               if (!dp_mute) begin
                  dpv <= 1'b1;
                  for (int c = 0; c < 4; c++) o[c] <= 13'(nx[c]);
               end
               for (int c = 0; c < 4; c++) acc[c] = 0;
            end else begin
               np++;
               for (int c = 0; c < 4; c++) acc[c] = nx[c];
            end
         end
      end
   end

   function automatic logic [51:0] golden(logic [127:0] a);
      logic [51:0] r = '0;
      for (int c = 0; c < 4; c++) begin
         int s = 0;
         for (int k = 0; k < 32; k++)
            s += int'(a[k*4 +: 4]) * wref[k][c];
         r[c*13 +: 13] = 13'(s);
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic set_w(int k, logic [15:0] d);
      for (int c = 0; c < 4; c++) wref[k][c] = int'(d[c*4 +: 4]);
   endtask

   task automatic wr(int k, logic [15:0] d);
      @(negedge clk);
      w_we = 1'b1;
      w_idx = 5'(k);
      w_data = d;
      @(negedge clk);
      w_we = 1'b0;
      set_w(k, d);
   endtask

   task automatic load_all(logic [15:0] w0, logic [15:0] wrest);
      for (int k = 0; k < 32; k++) wr(k, (k == 0) ? w0 : wrest);
   endtask

   task automatic load_rand();
      for (int k = 0; k < 32; k++) wr(k, 16'($urandom));
   endtask

   task automatic clr_ref();
      for (int k = 0; k < 32; k++) set_w(k, 16'h0);
      tag_m = 0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic start_row(logic [127:0] a);
      @(negedge clk);
      chk("act_ready", 64'(bus.act_ready), 64'd1);
      bus.act_valid = 1'b1;
      bus.act_data = a;
      @(negedge clk);
      bus.act_valid = 1'b0;
      bus.act_data = rnd128();
   endtask

   task automatic wait_res(output bit got);
      int n = 0;
      got = 1'b0;
      while (!bus.res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      got = bus.res_valid;
   endtask

   task automatic finish_row(string nm, logic [51:0] exp);
      bit got;
      wait_res(got);
      chk({nm, " res_valid"}, 64'(got), 64'd1);
      if (got) begin
         chk({nm, " res_data"}, 64'(bus.res_data), 64'(exp));
         chk({nm, " res_tag"}, 64'(bus.res_tag), 64'(tag_m));
         bus.res_ready = 1'b1;
         @(negedge clk);
         bus.res_ready = 1'b0;
         tag_m = (tag_m + 1) % 4;
      end
   endtask

   typedef struct {
      logic [15:0]  w0;
      logic [15:0]  wr;
      logic [127:0] act;
      logic [51:0]  exp;
      logic [15:0]  pl1;
      logic [15:0]  pl4;
      bit           nz;
   } vec_t;

   vec_t vt [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      int n, tp, nz, p0;
      bit sawres;
      logic [127:0] a;
      logic [51:0] e;

      bus.act_valid = 1'b0;
      bus.act_data = '0;
      bus.res_ready = 1'b0;
      clr_ref();

      vt[0] = '{16'hFFFF, 16'hFFFF, {128{1'b1}}, {4{13'd7200}},
                16'hFFFF, 16'hFFFF, 1'b1};
      vt[1] = '{16'h4321, 16'h0000, 128'hA,
                {13'd40, 13'd30, 13'd20, 13'd10},
                16'h1010, 16'h4040, 1'b0};
      vt[2] = '{16'h0000, 16'h1111, {32{4'h1}}, {4{13'd31}},
                16'h0000, 16'h0000, 1'b1};
      vt[3] = '{16'hF000, 16'h0000, 128'h5, {13'd75, 39'd0},
                16'h0000, 16'h0F0F, 1'b0};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst act_ready", 64'(bus.act_ready), 64'd0);
      chk("rst dp_in_valid", 64'(bus.dp_in_valid), 64'd0);
      chk("rst dp_in_data", 64'(|{bus.dp_in_data1, bus.dp_in_data2,
          bus.dp_in_data3, bus.dp_in_data4}), 64'd0);
      chk("rst res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst res_data", 64'(bus.res_data), 64'd0);
      chk("rst res_tag", 64'(bus.res_tag), 64'd0);
      chk("rst err", 64'(err), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle act_ready", 64'(bus.act_ready), 64'd1);

      // table-driven rows
      foreach (vt[i]) begin
         load_all(vt[i].w0, vt[i].wr);
         p0 = log1.size();
         tp = tot_planes;
         nz = nz_cnt;
         start_row(vt[i].act);
         finish_row($sformatf("vec%0d", i), vt[i].exp);
         chk($sformatf("vec%0d planes", i), 64'(tot_planes - tp), 64'd4);
         if (tot_planes - tp == 4) begin
            chk($sformatf("vec%0d pl1", i),
                64'({log1[p0], log1[p0+1], log1[p0+2], log1[p0+3]}),
                64'(vt[i].pl1));
            chk($sformatf("vec%0d pl4", i),
                64'({log4[p0], log4[p0+1], log4[p0+2], log4[p0+3]}),
                64'(vt[i].pl4));
         end
         chk($sformatf("vec%0d nz", i), 64'(nz_cnt != nz), 64'(vt[i].nz));
      end

      // weight write in the accept cycle is used by that row
      @(negedge clk);
      w_we = 1'b1;
      w_idx = 5'd0;
      w_data = 16'h000F;
      bus.act_valid = 1'b1;
      bus.act_data = 128'h1;
      @(negedge clk);
      w_we = 1'b0;
      bus.act_valid = 1'b0;
      set_w(0, 16'h000F);
      finish_row("samecyc", {39'd0, 13'd15});

      // long RESP stall; write during it must be dropped
      start_row(128'h5);
      wait_res(got);
      chk("stall got", 64'(got), 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk("stall res_valid", 64'(bus.res_valid), 64'd1);
         chk("stall res_data", 64'(bus.res_data), 64'(golden(128'h5)));
         chk("stall act_ready", 64'(bus.act_ready), 64'd0);
         w_we = (i == 3);
         w_idx = 5'd0;
         w_data = 16'hFFFF;
         @(negedge clk);
      end
      w_we = 1'b0;
      finish_row("stall", {39'd0, 13'd75});
      start_row(128'h5);
      finish_row("drop", {39'd0, 13'd75});

      // timeout: datapath never answers
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clr_ref();
      load_all(16'h1111, 16'h1111);
      dp_mute = 1'b1;
      start_row(rnd128());
      n = 0;
      sawres = 1'b0;
      while (!bus.act_ready && n < 300) begin
         if (bus.res_valid) sawres = 1'b1;
         n++;
         @(negedge clk);
      end
      chk("tmo cycles", 64'(n), 64'd68);
      chk("tmo res_valid", 64'(sawres), 64'd0);
      chk("tmo err", 64'(err), 64'd1);
      tag_m = (tag_m + 1) % 4;
      dp_mute = 1'b0;
      a = rnd128();
      start_row(a);
      finish_row("after tmo", golden(a));

      // back-to-back random rows with a spurious strobe
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clr_ref();
      load_rand();
      chk("b2b err0", 64'(err), 64'd0);
      for (int r = 0; r < 5; r++) begin
         if (r == 2) begin
            @(negedge clk);
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
            chk("spur err", 64'(err), 64'd1);
         end
         chk("b2b tag seq", 64'(tag_m), 64'(r % 4));
         tp = tot_planes;
         a = rnd128();
         start_row(a);
         finish_row($sformatf("b2b%0d", r), golden(a));
         chk("b2b planes", 64'(tot_planes - tp), 64'd4);
      end

      // reset during the second issue plane
      load_rand();
      a = rnd128();
      start_row(a);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid dp_in_valid", 64'(bus.dp_in_valid), 64'd0);
      chk("mid dp_in_data", 64'(|{bus.dp_in_data1, bus.dp_in_data2,
          bus.dp_in_data3, bus.dp_in_data4}), 64'd0);
      chk("mid act_ready", 64'(bus.act_ready), 64'd0);
      chk("mid err", 64'(err), 64'd0);
      chk("mid res_valid", 64'(bus.res_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clr_ref();
      @(negedge clk);
      chk("post act_ready", 64'(bus.act_ready), 64'd1);
      start_row(a);
      finish_row("wlost", 52'd0);
      load_rand();
      a = rnd128();
      e = golden(a);
      start_row(a);
      finish_row("reload", e);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
